// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter
// Merges the instruction-fetch read port (S0) and the load/store read/write
// port (S1) into one AXI-Lite master port feeding the crossbar. Only one
// transaction is in flight at a time. The grant is held from the address
// phase until the final response handshake. Payloads are never latched:
// the granted master is wired straight through to M_AXI_*.
//
// Optional feature macro: AXI_ARB_RR_EN
//   defined   -> round-robin between S0 and S1 using a 1-bit last-grant register
//   undefined -> fixed priority, S1 over S0
// In both builds an S1 write request wins over an S1 read request.
module axi_lite_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      AXI_ACLK,
  input  logic                      AXI_ARESETN,
  // S0: instruction fetch, read only
  input  logic [ADDR_WIDTH-1:0]     S0_ARADDR,
  input  logic                      S0_ARVALID,
  output logic                      S0_ARREADY,
  output logic [DATA_WIDTH-1:0]     S0_RDATA,
  output logic [1:0]                S0_RRESP,
  output logic                      S0_RVALID,
  input  logic                      S0_RREADY,
  // S1: load/store, read and write
  input  logic [ADDR_WIDTH-1:0]     S1_ARADDR,
  input  logic                      S1_ARVALID,
  output logic                      S1_ARREADY,
  output logic [DATA_WIDTH-1:0]     S1_RDATA,
  output logic [1:0]                S1_RRESP,
  output logic                      S1_RVALID,
  input  logic                      S1_RREADY,
  input  logic [ADDR_WIDTH-1:0]     S1_AWADDR,
  input  logic                      S1_AWVALID,
  output logic                      S1_AWREADY,
  input  logic [DATA_WIDTH-1:0]     S1_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   S1_WSTRB,
  input  logic                      S1_WVALID,
  output logic                      S1_WREADY,
  output logic [1:0]                S1_BRESP,
  output logic                      S1_BVALID,
  input  logic                      S1_BREADY,
  // Single master port toward the crossbar
  output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GNT_S0_RD = 2'd1,
    GNT_S1_RD = 2'd2,
    GNT_S1_WR = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Per-grant completion flags for the two write address/data halves. AW and
  // W may complete in any order; B is only passed back once both are done,
  // and a completed half is not forwarded a second time.
  logic aw_done_q, aw_done_d;
  logic w_done_q,  w_done_d;

  // Request decode, only acted upon in IDLE
  logic s0_rd_req, s1_rd_req, s1_wr_req, s1_req;
  logic pick_s0;

  assign s0_rd_req = S0_ARVALID;
  assign s1_rd_req = S1_ARVALID;
  assign s1_wr_req = S1_AWVALID | S1_WVALID;
  assign s1_req    = s1_rd_req | s1_wr_req;

`ifdef AXI_ARB_RR_EN
  // 1 = S1 received the most recent grant; on contention the other master wins
  logic last_s1_q, last_s1_d;

  assign pick_s0 = s0_rd_req & (~s1_req | last_s1_q);

  // Last-grant register, updated whenever IDLE hands out a grant
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      last_s1_q <= 1'b1;
    end else begin
      last_s1_q <= last_s1_d;
    end
  end

  // Next last-grant value: record who leaves IDLE with the grant
  always_comb begin
    last_s1_d = last_s1_q;
    if ((state_q == IDLE) && (state_d != IDLE)) begin
      last_s1_d = (state_d != GNT_S0_RD);
    end
  end
`else
  assign pick_s0 = s0_rd_req & ~s1_req;
`endif

  // State and write-phase flags; async reset abandons any in-flight transfer
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Next-state: grant selection in IDLE, release on the final response handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_s0) begin
          state_d = GNT_S0_RD;
        end else if (s1_wr_req) begin
          state_d = GNT_S1_WR;
        end else if (s1_rd_req) begin
          state_d = GNT_S1_RD;
        end
      end
      GNT_S0_RD: begin
        if (M_AXI_RVALID && S0_RREADY) state_d = IDLE;
      end
      GNT_S1_RD: begin
        if (M_AXI_RVALID && S1_RREADY) state_d = IDLE;
      end
      GNT_S1_WR: begin
        if (M_AXI_BVALID && S1_BREADY && aw_done_q && w_done_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write-phase flags: set on each half's handshake, cleared outside the write grant
  always_comb begin
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    if (state_q != GNT_S1_WR) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end else begin
      if (S1_AWVALID && M_AXI_AWREADY) aw_done_d = 1'b1;
      if (S1_WVALID  && M_AXI_WREADY)  w_done_d  = 1'b1;
    end
  end

  // Channel steering: everything 0 unless the granted master's path is connected
  always_comb begin
    S0_ARREADY    = 1'b0;
    S0_RDATA      = '0;
    S0_RRESP      = 2'b00;
    S0_RVALID     = 1'b0;
    S1_ARREADY    = 1'b0;
    S1_RDATA      = '0;
    S1_RRESP      = 2'b00;
    S1_RVALID     = 1'b0;
    S1_AWREADY    = 1'b0;
    S1_WREADY     = 1'b0;
    S1_BRESP      = 2'b00;
    S1_BVALID     = 1'b0;
    M_AXI_AWADDR  = '0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WDATA   = '0;
    M_AXI_WSTRB   = '0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARADDR  = '0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    case (state_q)
      GNT_S0_RD: begin
        M_AXI_ARADDR  = S0_ARADDR;
        M_AXI_ARVALID = S0_ARVALID;
        S0_ARREADY    = M_AXI_ARREADY;
        S0_RDATA      = M_AXI_RDATA;
        S0_RRESP      = M_AXI_RRESP;
        S0_RVALID     = M_AXI_RVALID;
        M_AXI_RREADY  = S0_RREADY;
      end
      GNT_S1_RD: begin
        M_AXI_ARADDR  = S1_ARADDR;
        M_AXI_ARVALID = S1_ARVALID;
        S1_ARREADY    = M_AXI_ARREADY;
        S1_RDATA      = M_AXI_RDATA;
        S1_RRESP      = M_AXI_RRESP;
        S1_RVALID     = M_AXI_RVALID;
        M_AXI_RREADY  = S1_RREADY;
      end
      GNT_S1_WR: begin
        if (!aw_done_q) begin
          M_AXI_AWADDR  = S1_AWADDR;
          M_AXI_AWVALID = S1_AWVALID;
          S1_AWREADY    = M_AXI_AWREADY;
        end
        if (!w_done_q) begin
          M_AXI_WDATA  = S1_WDATA;
          M_AXI_WSTRB  = S1_WSTRB;
          M_AXI_WVALID = S1_WVALID;
          S1_WREADY    = M_AXI_WREADY;
        end
        if (aw_done_q && w_done_q) begin
          S1_BRESP     = M_AXI_BRESP;
          S1_BVALID    = M_AXI_BVALID;
          M_AXI_BREADY = S1_BREADY;
        end
      end
      default: ;
    endcase
  end

endmodule
